// File: rtl/core_fetch_port.sv
// core_fetch_port
//
// Purpose:
//   Owns the instruction fetch address and drives a single-outstanding
//   word-read port toward the instruction bus/cache. Each completed read is
//   returned as one registered instruction word on o_fetched/o_fetch_data.
//   A flush redirects fetching to a new target and throws away any response
//   that still belongs to the pre-flush instruction stream.
//
// Parameters:
//   RESET_PC      word address (byte address >> 2) of the first fetch after reset
//
// Ports:
//   clk           core clock
//   rst           asynchronous, active-high reset
//   i_fetch       prefetch buffer has room / requests another word
//   i_flush       redirect, same cycle as the prefetch flush
//   i_target      redirect word address, valid when i_flush=1
//   i_bus_ready   read completes this cycle
//   i_bus_data    read data, valid when i_bus_ready=1
//   i_bus_fault   (CORE_FETCH_ABORT_EN only) completing read has faulted
//   o_bus_req     read request, level; held until a cycle with i_bus_ready=1
//   o_bus_addr    read word address, valid while o_bus_req=1
//   o_fetched     registered one-cycle pulse: o_fetch_data is valid
//   o_fetch_data  registered instruction word
//   o_abort       (CORE_FETCH_ABORT_EN only) a fetch faulted; held until flush
//   o_head        redirect PC for the prefetch buffer
//
// Build option:
//   CORE_FETCH_ABORT_EN  adds i_bus_fault/o_abort and a FAULT state that
//                        parks the port after a faulted read until a flush.

module core_fetch_port #(
    parameter logic [29:0] RESET_PC = 30'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_fetch,
    input  logic        i_flush,
    input  logic [29:0] i_target,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_data,
`ifdef CORE_FETCH_ABORT_EN
    input  logic        i_bus_fault,
`endif
    output logic        o_bus_req,
    output logic [29:0] o_bus_addr,
    output logic        o_fetched,
    output logic [31:0] o_fetch_data,
`ifdef CORE_FETCH_ABORT_EN
    output logic        o_abort,
`endif
    output logic [29:0] o_head
);

`ifdef CORE_FETCH_ABORT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DISCARD, ST_FAULT} state_t;
    localparam logic [31:0] NOP_WORD = 32'hE1A00000;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DISCARD} state_t;
`endif

    state_t      r_state;
    state_t      w_nextState;
    logic [29:0] r_addr;
    logic [29:0] r_reqAddr;
    logic [29:0] r_head;
    logic        r_fetched;
    logic [31:0] r_fetchData;
    logic        w_busReq;
    logic [29:0] w_busAddr;
    logic        w_complete;
    logic [29:0] w_addrInc;
`ifdef CORE_FETCH_ABORT_EN
    logic        r_abort;
`endif

    assign w_addrInc = r_addr + 30'd1;

    // Next-state and bus request decode. w_complete marks a read whose data
    // belongs to the live stream; completions in DISCARD or in a flush cycle
    // never raise it, so stale data cannot reach the prefetch buffer.
    // In IDLE the request is raised combinationally so a zero-wait bus can
    // complete the read in the same cycle it was asked for.
    always_comb begin
        w_nextState = r_state;
        w_busReq    = 1'b0;
        w_busAddr   = r_reqAddr;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_flush && i_fetch) begin
                    w_busReq    = 1'b1;
                    w_busAddr   = r_addr;
                    w_nextState = ST_BUSY;
                    w_complete  = i_bus_ready;
                end
            end
            ST_BUSY: begin
                w_busReq = 1'b1;
                if (i_flush) begin
                    w_nextState = i_bus_ready ? ST_IDLE : ST_DISCARD;
                end else begin
                    w_complete = i_bus_ready;
                end
            end
            ST_DISCARD: begin
                // The old request must still be honoured; its data is dropped.
                w_busReq = 1'b1;
                if (i_bus_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
`ifdef CORE_FETCH_ABORT_EN
            ST_FAULT: begin
                if (i_flush) begin
                    w_nextState = ST_IDLE;
                end
            end
`endif
            default: w_nextState = ST_IDLE;
        endcase
        if (w_complete) begin
            w_nextState = i_fetch ? ST_BUSY : ST_IDLE;
`ifdef CORE_FETCH_ABORT_EN
            if (i_bus_fault) begin
                w_nextState = ST_FAULT;
            end
`endif
        end
    end

    // State, fetch address and response registers. r_reqAddr captures the
    // address at request start so the bus address stays stable even after a
    // flush has already moved r_addr to the redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= RESET_PC;
            r_reqAddr   <= RESET_PC;
            r_head      <= RESET_PC;
            r_fetched   <= 1'b0;
            r_fetchData <= 32'd0;
`ifdef CORE_FETCH_ABORT_EN
            r_abort     <= 1'b0;
`endif
        end else begin
            r_state   <= w_nextState;
            r_fetched <= w_complete;
            if (r_state == ST_IDLE && w_busReq) begin
                r_reqAddr <= r_addr;
            end
            if (w_complete) begin
                r_fetchData <= i_bus_data;
                r_addr      <= w_addrInc;
                if (i_fetch) begin
                    r_reqAddr <= w_addrInc;
                end
`ifdef CORE_FETCH_ABORT_EN
                if (i_bus_fault) begin
                    r_fetchData <= NOP_WORD;
                    r_addr      <= r_addr;
                    r_abort     <= 1'b1;
                end
`endif
            end
            if (i_flush) begin
                r_addr <= i_target;
                r_head <= i_target;
`ifdef CORE_FETCH_ABORT_EN
                if (r_state == ST_FAULT) begin
                    r_abort <= 1'b0;
                end
`endif
            end
        end
    end

    assign o_bus_req    = w_busReq;
    assign o_bus_addr   = w_busAddr;
    assign o_fetched    = r_fetched;
    assign o_fetch_data = r_fetchData;
    assign o_head       = i_flush ? i_target : r_head;
`ifdef CORE_FETCH_ABORT_EN
    assign o_abort      = r_abort;
`endif

endmodule

// File: tb/tb_core_fetch_port.sv
// tb_core_fetch_port
//
// Self-checking bench for core_fetch_port (RESET_PC = 30'h10).
// A directed vector table covers the streaming, wait-state, flush/discard and
// address-wrap corners; a randomized run compares the DUT each cycle against
// a transaction-level model (one outstanding read with a stale flag).

module tb_core_fetch_port;

    localparam logic [29:0] RPC = 30'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] target = '0;
    logic        busReady = 1'b0;
    logic [31:0] busData = '0;
    logic        busReq;
    logic [29:0] busAddr;
    logic        fetched;
    logic [31:0] fetchData;
    logic [29:0] head;
`ifdef CORE_FETCH_ABORT_EN
    logic        busFault = 1'b0;
    logic        abort;
`endif

    int nChecks = 0;
    int nPass   = 0;

    core_fetch_port #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_fetch      (fetch),
        .i_flush      (flush),
        .i_target     (target),
        .i_bus_ready  (busReady),
        .i_bus_data   (busData),
`ifdef CORE_FETCH_ABORT_EN
        .i_bus_fault  (busFault),
`endif
        .o_bus_req    (busReq),
        .o_bus_addr   (busAddr),
        .o_fetched    (fetched),
        .o_fetch_data (fetchData),
`ifdef CORE_FETCH_ABORT_EN
        .o_abort      (abort),
`endif
        .o_head       (head)
    );

    always #5 clk = ~clk;

    // One directed cycle: inputs plus the outputs expected during that cycle.
    typedef struct {
        logic        fetch;
        logic        flush;
        logic [29:0] target;
        logic        ready;
        logic [31:0] data;
        logic        expReq;
        logic [29:0] expAddr;
        logic [29:0] expHead;
        logic        expFetched;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: next PC, at most one outstanding read and whether
    // that read belongs to a stream abandoned by a flush.
    logic        mOut;
    logic [29:0] mOutAddr;
    logic        mStale;
    logic [29:0] mPc;
    logic [29:0] mHead;
    logic        mFetched;
    logic [31:0] mData;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    endtask

    // Drive one cycle's inputs away from the active edge, then let them settle.
    task automatic applyStimulus(input logic f, input logic fl, input logic [29:0] t,
                                 input logic r, input logic [31:0] d);
        @(negedge clk);
        fetch = f; flush = fl; target = t; busReady = r; busData = d;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        fetch = 0; flush = 0; target = '0; busReady = 0; busData = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mOut = 0; mOutAddr = '0; mStale = 0; mPc = RPC; mHead = RPC; mFetched = 0; mData = '0;
    endtask

    task automatic addVec(input logic f, input logic fl, input logic [29:0] t, input logic r,
                          input logic [31:0] d, input logic eq, input logic [29:0] ea,
                          input logic [29:0] eh, input logic ef, input logic [31:0] ed);
        vec_t v;
        v.fetch = f; v.flush = fl; v.target = t; v.ready = r; v.data = d;
        v.expReq = eq; v.expAddr = ea; v.expHead = eh; v.expFetched = ef; v.expData = ed;
        vecs.push_back(v);
    endtask

    // Check the current cycle against the model, then advance the model
    // across the coming clock edge.
    task automatic modelCycle(input string tag);
        logic        eReq;
        logic [29:0] eAddr;
        logic        done;
        eReq  = mOut || (!flush && fetch);
        eAddr = mOut ? mOutAddr : mPc;
        checkOutput({tag, " bus_req"}, 32'(busReq), 32'(eReq));
        if (eReq) checkOutput({tag, " bus_addr"}, 32'(busAddr), 32'(eAddr));
        checkOutput({tag, " head"}, 32'(head), 32'(flush ? target : mHead));
        checkOutput({tag, " fetched"}, 32'(fetched), 32'(mFetched));
        if (mFetched) checkOutput({tag, " fetch_data"}, fetchData, mData);

        done     = eReq && busReady;
        mFetched = 0;
        if (flush) begin
            mPc   = target;
            mHead = target;
            if (mOut && !done) mStale = 1;
            else mOut = 0;
        end else if (done) begin
            if (mOut && mStale) begin
                mOut = 0;
            end else begin
                mFetched = 1;
                mData    = busData;
                mPc      = mPc + 30'd1;
                if (fetch) begin
                    mOut = 1; mOutAddr = mPc; mStale = 0;
                end else begin
                    mOut = 0;
                end
            end
        end else if (eReq && !mOut) begin
            mOut = 1; mOutAddr = eAddr; mStale = 0;
        end
    endtask

    initial begin
        // Streaming with a zero-wait bus, then a completion with fetch=0.
        addVec(1, 0, 0,          1, 32'hA000_0000, 1, 30'h10,       30'h10,       0, 0);
        addVec(1, 0, 0,          1, 32'hA000_0001, 1, 30'h11,       30'h10,       1, 32'hA000_0000);
        addVec(1, 0, 0,          1, 32'hA000_0002, 1, 30'h12,       30'h10,       1, 32'hA000_0001);
        addVec(0, 0, 0,          0, 32'h0,         1, 30'h13,       30'h10,       1, 32'hA000_0002);
        addVec(0, 0, 0,          1, 32'hA000_0003, 1, 30'h13,       30'h10,       0, 0);
        addVec(0, 0, 0,          0, 32'h0,         0, 30'h0,        30'h10,       1, 32'hA000_0003);
        // Flush in IDLE to 0x20, then a read held for three wait cycles.
        addVec(1, 1, 30'h20,     0, 32'h0,         0, 30'h0,        30'h20,       0, 0);
        addVec(1, 0, 0,          0, 32'h0,         1, 30'h20,       30'h20,       0, 0);
        addVec(0, 0, 0,          0, 32'h0,         1, 30'h20,       30'h20,       0, 0);
        addVec(0, 0, 0,          0, 32'h0,         1, 30'h20,       30'h20,       0, 0);
        addVec(1, 0, 0,          1, 32'hB000_0000, 1, 30'h20,       30'h20,       0, 0);
        // Flush to 0x400 while BUSY on 0x21: DISCARD keeps 0x21, data dropped.
        addVec(1, 0, 0,          0, 32'h0,         1, 30'h21,       30'h20,       1, 32'hB000_0000);
        addVec(1, 1, 30'h400,    0, 32'h0,         1, 30'h21,       30'h400,      0, 0);
        addVec(1, 0, 0,          0, 32'h0,         1, 30'h21,       30'h400,      0, 0);
        addVec(1, 0, 0,          1, 32'hDEAD_BEEF, 1, 30'h21,       30'h400,      0, 0);
        addVec(1, 0, 0,          0, 32'h0,         1, 30'h400,      30'h400,      0, 0);
        addVec(1, 0, 0,          1, 32'hC000_0000, 1, 30'h400,      30'h400,      0, 0);
        // Flush coincident with bus_ready: that completion is dropped.
        addVec(1, 1, 30'h3FFFFFFF, 1, 32'hC000_0001, 1, 30'h401,    30'h3FFFFFFF, 1, 32'hC000_0000);
        addVec(1, 0, 0,          0, 32'h0,         1, 30'h3FFFFFFF, 30'h3FFFFFFF, 0, 0);
        // Completion at the top address with fetch=0, then wrap to 0.
        addVec(0, 0, 0,          1, 32'hC000_0003, 1, 30'h3FFFFFFF, 30'h3FFFFFFF, 0, 0);
        addVec(0, 0, 0,          0, 32'h0,         0, 30'h0,        30'h3FFFFFFF, 1, 32'hC000_0003);
        addVec(1, 0, 0,          0, 32'h0,         1, 30'h0,        30'h3FFFFFFF, 0, 0);

        doReset();
        #1;
        checkOutput("reset bus_req", 32'(busReq), 32'd0);
        checkOutput("reset fetched", 32'(fetched), 32'd0);
        checkOutput("reset fetch_data", fetchData, 32'd0);
        checkOutput("reset head", 32'(head), 32'(RPC));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].fetch, vecs[i].flush, vecs[i].target, vecs[i].ready, vecs[i].data);
            checkOutput($sformatf("vec%0d bus_req", i), 32'(busReq), 32'(vecs[i].expReq));
            if (vecs[i].expReq)
                checkOutput($sformatf("vec%0d bus_addr", i), 32'(busAddr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d head", i), 32'(head), 32'(vecs[i].expHead));
            checkOutput($sformatf("vec%0d fetched", i), 32'(fetched), 32'(vecs[i].expFetched));
            if (vecs[i].expFetched)
                checkOutput($sformatf("vec%0d fetch_data", i), fetchData, vecs[i].expData);
        end

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic [29:0] t;
            t = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFE : 30'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, t,
                          1'($urandom_range(0, 1)), $urandom);
            modelCycle("rand");
        end

        // Asynchronous reset in the middle of an outstanding read.
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("midrst busy bus_req", 32'(busReq), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst bus_req", 32'(busReq), 32'd0);
        checkOutput("midrst head", 32'(head), 32'(RPC));
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("postrst bus_addr", 32'(busAddr), 32'(RPC));

`ifdef CORE_FETCH_ABORT_EN
        // Faulted read parks the port until a flush.
        doReset();
        applyStimulus(0, 1, 30'h8, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("fault req addr", 32'(busAddr), 32'h8);
        busFault = 1'b1;
        applyStimulus(1, 0, 0, 1, 32'h1234_5678);
        busFault = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("fault fetched", 32'(fetched), 32'd1);
        checkOutput("fault nop", fetchData, 32'hE1A00000);
        checkOutput("fault abort", 32'(abort), 32'd1);
        checkOutput("fault no req", 32'(busReq), 32'd0);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("fault held req", 32'(busReq), 32'd0);
        checkOutput("fault held abort", 32'(abort), 32'd1);
        applyStimulus(1, 1, 30'h3, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("fault clr abort", 32'(abort), 32'd0);
        checkOutput("fault resume req", 32'(busReq), 32'd1);
        checkOutput("fault resume addr", 32'(busAddr), 32'h3);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
